// File: rtl/prio_arbiter_pkg.sv
// Shared types and default sizing for the priority arbiter.
package prio_arbiter_pkg;

  localparam int unsigned DEF_NREQ  = 3;
  localparam int unsigned DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/prio_arbiter_rr_pick.sv
// Combinational winner search: first set request starting at the
// search origin (index 0 in fixed mode, start in round-robin mode).
module rr_pick
  import prio_arbiter_pkg::*;
#(
  parameter  int unsigned NREQ = DEF_NREQ,
  localparam int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   start,
  input  logic            mode,
  output logic            valid_c,
  output logic [IW-1:0]   idx_c
);

  int base;
  int k;

  // Scan requesters from the origin, wrapping past the top index.
  always_comb begin
    valid_c = 1'b0;
    idx_c   = '0;
    k       = 0;
    base    = mode ? int'(start) : 0;
    for (int i = 0; i < int'(NREQ); i++) begin
      k = base + i;
      if (k >= int'(NREQ)) k = k - int'(NREQ);
      if (!valid_c && req[k]) begin
        valid_c = 1'b1;
        idx_c   = IW'(k);
      end
    end
  end

endmodule

// File: rtl/prio_arbiter.sv
// Fixed/round-robin arbiter with grant-length limit and one-cycle gap
// between grants.
module prio_arbiter
  import prio_arbiter_pkg::*;
#(
  parameter  int unsigned NREQ  = DEF_NREQ,
  parameter  int unsigned CNT_W = DEF_CNT_W,
  localparam int unsigned IW    = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic             rel,
  input  logic             mode,
  input  logic [CNT_W-1:0] limit,
  output logic [NREQ-1:0]  gnt,
  output logic [IW-1:0]    gnt_id,
  output logic             busy,
  output logic             tmo
);

  state_t           state_q, state_d;
  logic [NREQ-1:0]  gnt_d;
  logic [IW-1:0]    gnt_id_d;
  logic             busy_d, tmo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lim_q, lim_d;
  logic [IW-1:0]    rr_start;
  logic             pick_valid;
  logic [IW-1:0]    pick_idx;
  logic             expire, drop;

  // Round-robin search origin: one past the last grantee, wrapping.
  assign rr_start = (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + IW'(1);

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req),
    .start   (rr_start),
    .mode    (mode),
    .valid_c (pick_valid),
    .idx_c   (pick_idx)
  );

  // State, counter, latched limit and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt     <= '0;
      gnt_id  <= IW'(NREQ - 1);
      busy    <= 1'b0;
      tmo     <= 1'b0;
      cnt_q   <= '0;
      lim_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      gnt_id  <= gnt_id_d;
      busy    <= busy_d;
      tmo     <= tmo_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
    end
  end

  // Next state and next output values; GAP arbitrates like IDLE.
  always_comb begin
    state_d  = state_q;
    gnt_d    = '0;
    gnt_id_d = gnt_id;
    busy_d   = 1'b0;
    tmo_d    = 1'b0;
    cnt_d    = cnt_q;
    lim_d    = lim_q;
    expire   = (lim_q != '0) && (cnt_q == lim_q);
    drop     = !req[gnt_id];
    case (state_q)
      IDLE, GAP: begin
        if (pick_valid) begin
          state_d  = GRANT;
          gnt_d    = NREQ'(1) << pick_idx;
          gnt_id_d = pick_idx;
          busy_d   = 1'b1;
          cnt_d    = CNT_W'(1);
          lim_d    = limit;
        end else begin
          state_d  = IDLE;
        end
      end
      GRANT: begin
        if (rel || drop || expire) begin
          state_d = GAP;
          tmo_d   = expire && !rel && !drop;
          cnt_d   = '0;
        end else begin
          gnt_d  = gnt;
          busy_d = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_prio_arbiter.sv
// Directed bench for prio_arbiter (NREQ=3, CNT_W=8).
module tb_prio_arbiter;

  logic       clk;
  logic       rst_n;
  logic [2:0] req;
  logic       rel;
  logic       mode;
  logic [7:0] limit;
  logic [2:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       tmo;

  int total = 0;
  int bad   = 0;

  prio_arbiter #(.NREQ(3), .CNT_W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .rel    (rel),
    .mode   (mode),
    .limit  (limit),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy),
    .tmo    (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] eg, input logic [1:0] eid,
                         input logic eb, input logic et);
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".gnt_id"}, 32'(gnt_id), 32'(eid));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".tmo"}, 32'(tmo), 32'(et));
  endtask

  initial begin
    logic [1:0] rr_order [4];
    rr_order = '{2'd0, 2'd1, 2'd2, 2'd0};
    rst_n = 1'b0; req = '0; rel = 1'b0; mode = 1'b0; limit = '0;

    // reset values
    repeat (2) tick();
    chk_all("reset", 3'b000, 2'd2, 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // fixed priority, rel on 4th grant cycle, regrant after gap
    req = 3'b110;
    tick(); chk_all("fix.c1", 3'b010, 2'd1, 1'b1, 1'b0);
    tick(); tick();
    tick(); chk("fix.c4", 32'(gnt), 32'(3'b010));
    rel = 1'b1;
    tick(); rel = 1'b0;
    chk_all("fix.gap", 3'b000, 2'd1, 1'b0, 1'b0);
    tick(); chk_all("fix.regrant", 3'b010, 2'd1, 1'b1, 1'b0);
    req = 3'b000;
    tick(); chk("fix.drop", 32'(gnt), 32'(3'b000));
    tick();
    rel = 1'b1;
    tick(); rel = 1'b0;
    chk_all("idle.rel_ignored", 3'b000, 2'd1, 1'b0, 1'b0);

    // round-robin from reset: order 0,1,2,0
    rst_n = 1'b0;
    #2 chk("rr.reset_id", 32'(gnt_id), 32'(2'd2));
    @(negedge clk); rst_n = 1'b1;
    mode = 1'b1; req = 3'b111;
    for (int n = 0; n < 4; n++) begin
      tick(); chk_all($sformatf("rr.g%0d", n), 3'b001 << rr_order[n], rr_order[n], 1'b1, 1'b0);
      tick(); rel = 1'b1;
      tick(); rel = 1'b0;
      chk_all($sformatf("rr.gap%0d", n), 3'b000, rr_order[n], 1'b0, 1'b0);
    end
    req = 3'b000;
    tick();

    // limit expiry; limit changed mid-grant must not matter
    mode = 1'b0; limit = 8'd4; req = 3'b001;
    tick(); chk_all("lim.c1", 3'b001, 2'd0, 1'b1, 1'b0);
    limit = 8'd1;
    tick(); chk_all("lim.c2", 3'b001, 2'd0, 1'b1, 1'b0);
    limit = 8'd4;
    tick(); chk_all("lim.c3", 3'b001, 2'd0, 1'b1, 1'b0);
    tick(); chk_all("lim.c4", 3'b001, 2'd0, 1'b1, 1'b0);
    tick(); chk_all("lim.revoke", 3'b000, 2'd0, 1'b0, 1'b1);
    tick(); chk_all("lim.regrant", 3'b001, 2'd0, 1'b1, 1'b0);

    // rel coincident with expiry: no tmo
    tick(); tick();
    tick(); chk("limrel.c4", 32'(gnt), 32'(3'b001));
    rel = 1'b1;
    tick(); rel = 1'b0;
    chk_all("limrel.end", 3'b000, 2'd0, 1'b0, 1'b0);
    req = 3'b000; limit = 8'd0;
    tick();

    // grantee drops request with req[2] pending
    req = 3'b101;
    tick(); chk_all("drop.c1", 3'b001, 2'd0, 1'b1, 1'b0);
    tick();
    req = 3'b100;
    tick(); chk_all("drop.gap", 3'b000, 2'd0, 1'b0, 1'b0);
    tick(); chk_all("drop.next", 3'b100, 2'd2, 1'b1, 1'b0);
    req = 3'b000;
    tick(); tick();

    // mode change mid-grant ignored; reset mid-grant; RR restarts at 0
    req = 3'b001;
    tick(); chk_all("rst.c1", 3'b001, 2'd0, 1'b1, 1'b0);
    mode = 1'b1; req = 3'b111;
    tick(); chk_all("rst.c2", 3'b001, 2'd0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_all("rst.async", 3'b000, 2'd2, 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    tick(); chk_all("rst.first", 3'b001, 2'd0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prio_arbiter.md
PRIO_ARBITER -- requirements
Module: prio_arbiter

Interface
REQ-001 Parameter NREQ, default 3, number of requesters (2..8).
REQ-002 Parameter CNT_W, default 8, width of grant-duration counter and limit input.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  NREQ  per-requester request level, held high until serviced.
REQ-006 rel  input  1  release strobe from current grantee, one cycle.
REQ-007 mode  input  1  0 = fixed priority (index 0 highest), 1 = round-robin.
REQ-008 limit  input  CNT_W  max grant length in cycles; 0 = unlimited.
REQ-009 gnt  output  NREQ  one-hot grant, registered; all-zero when no grant.
REQ-010 gnt_id  output  clog2(NREQ)  index of current grantee; holds last grantee when idle.
REQ-011 busy  output  1  high while in GRANT state.
REQ-012 tmo  output  1  one-cycle pulse when a grant is revoked by limit expiry.

Function
REQ-013 FSM SHALL have states IDLE, GRANT, GAP.
REQ-014 IDLE: if any req bit high, select winner, go GRANT next edge; gnt asserted exactly one cycle after req first sampled high.
REQ-015 Fixed priority: winner = lowest set index of req.
REQ-016 Round-robin: search starts at (gnt_id+1) mod NREQ, wraps past NREQ-1 to 0; first set bit wins.
REQ-017 On entry to GRANT, limit SHALL be latched; later changes to limit have no effect on the current grant.
REQ-018 In GRANT, grant-duration counter SHALL start at 1 on first grant cycle and increment each cycle, saturating at all-ones.
REQ-019 GRANT -> GAP when rel high, or req[gnt_id] low, or (latched limit != 0 and counter == latched limit); gnt cleared on that same edge.
REQ-020 tmo SHALL pulse on the GAP-entry edge only when limit expiry is the cause and rel and req drop are both absent in that cycle; rel has precedence.
REQ-021 GAP lasts exactly one cycle with gnt zero, then IDLE arbitration rules apply (re-arbitration; same requester may win again under fixed priority).
REQ-022 mode SHALL be sampled only at arbitration; changing mode mid-grant does not affect the current grant.
REQ-023 rel while not in GRANT SHALL be ignored.
REQ-024 gnt SHALL never have more than one bit set; gnt_id valid whenever busy.
REQ-025 Requests arriving during GRANT or GAP are queued only by their level; no request is latched internally.

Reset
REQ-026 Asynchronous assertion of rst_n low SHALL force state IDLE, gnt=0, gnt_id=NREQ-1 (so first round-robin search starts at 0), busy=0, tmo=0, counter=0, latched limit=0.
REQ-027 Reset mid-grant SHALL drop gnt immediately without tmo; first arbitration after release of reset occurs on the first posedge with rst_n high.

Structure
REQ-028 Shared package SHALL hold the FSM state enum (IDLE, GRANT, GAP) and the default NREQ/CNT_W constants.
REQ-029 A sub-module rr_pick SHALL implement the combinational winner search (req, start index, mode) -> (valid, index); FSM, counter and outputs stay in prio_arbiter.

Verification
REQ-030 Fixed mode, req=3'b110 at cycle 0 -> gnt=3'b010, gnt_id=1 at cycle 1; rel at cycle 4 -> gnt=0 at cycle 5 (GAP), gnt=3'b010 at cycle 6.
REQ-031 Round-robin, req=3'b111 held, rel each grant's second cycle -> grant order 0,1,2,0 with one idle gap cycle between each.
REQ-032 limit=4, req=3'b001 held, no rel -> gnt high exactly 4 cycles, tmo pulses once on revoke edge, regrant after one-cycle gap.
REQ-033 limit=4 with rel on 4th grant cycle -> grant ends same edge, tmo stays 0.
REQ-034 Grantee drops req mid-grant with req[2] pending -> gnt clears next edge, req[2] granted two cycles later, tmo=0.
REQ-035 rst_n pulsed low during GRANT -> gnt, busy, tmo zero asynchronously; after reset release, round-robin with req=3'b111 grants index 0 first.
